// File: rtl/audio_defs.sv
// Shared constants for the audio output path: frame geometry and serial format codes.
package audio_defs;

    localparam int FRAME_CLKS    = 512;
    localparam int SLOT_BITS     = 32;
    localparam int SCLK_DIV_LOG2 = 3;
    localparam int CNT_W         = $clog2(FRAME_CLKS);

    localparam int FMT_I2S = 0;
    localparam int FMT_LJ  = 1;

    typedef logic [CNT_W-1:0] frame_cnt_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame counter; every DAC clock is a single counter bit, so all pins are flop outputs.
module i2s_clkgen
    import audio_defs::*;
#(
    parameter int FMT = FMT_I2S
) (
    input  logic clk,
    input  logic rst,
    output logic mclk,
    output logic sclk,
    output logic lrclk,
    output logic load_en,
    output logic shift_en
);

    frame_cnt_t cnt_q;
    frame_cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mclk  = cnt_q[0];
    assign sclk  = cnt_q[SCLK_DIV_LOG2-1];
    // Left-justified puts the left word in the LRCLK-high half.
    assign lrclk = (FMT == FMT_LJ) ? ~cnt_q[CNT_W-1] : cnt_q[CNT_W-1];

    assign load_en  = (cnt_q == CNT_W'(FRAME_CLKS - 1));
    assign shift_en = (cnt_q[SCLK_DIV_LOG2-1:0] == {SCLK_DIV_LOG2{1'b1}});

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified stereo DAC transmitter: latches a processed L/R pair per frame
// and shifts it out MSB first on SCLK falling edges.
module i2s_dac_tx
    import audio_defs::*;
#(
    parameter int DW  = 16,
    parameter int FMT = FMT_I2S
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] left,
    input  logic [DW-1:0] right,
    input  logic          mute,
    input  logic [3:0]    att,
    output logic          sample_strobe,
    output logic          mclk,
    output logic          sclk,
    output logic          lrclk,
    output logic          sdin
);

    localparam int FW = 2 * SLOT_BITS;

    logic          load_en;
    logic          shift_en;
    logic [FW-1:0] frame_q;
    logic [FW-1:0] frame_d;
    logic [FW-1:0] load_frame;
    logic          sdin_q;
    logic          sdin_d;
    logic          strobe_q;

    // Attenuate/mute one sample and place it in a 32-bit slot; I2S adds the one-bit delay.
    function automatic logic [SLOT_BITS-1:0] build_slot(input logic [DW-1:0] x,
                                                         input logic          m,
                                                         input logic [3:0]    a);
        logic signed [DW-1:0] s;
        logic [SLOT_BITS-1:0] lj;
        if (m) begin
            s = '0;
        end else begin
            s = $signed(x) >>> a;
        end
        lj = {s, {(SLOT_BITS-DW){1'b0}}};
        if (FMT == FMT_LJ) begin
            return lj;
        end else begin
            return lj >> 5'd1;
        end
    endfunction

    i2s_clkgen #(
        .FMT(FMT)
    ) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .mclk    (mclk),
        .sclk    (sclk),
        .lrclk   (lrclk),
        .load_en (load_en),
        .shift_en(shift_en)
    );

    // The load edge is also a shift edge, so the new frame's MSB goes straight to sdin.
    always_comb begin
        load_frame = {build_slot(left, mute, att), build_slot(right, mute, att)};
        frame_d    = frame_q;
        sdin_d     = sdin_q;
        if (load_en) begin
            sdin_d  = load_frame[FW-1];
            frame_d = {load_frame[FW-2:0], 1'b0};
        end else if (shift_en) begin
            sdin_d  = frame_q[FW-1];
            frame_d = {frame_q[FW-2:0], 1'b0};
        end else begin
            frame_d = frame_q;
            sdin_d  = sdin_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q  <= '0;
            sdin_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            sdin_q   <= sdin_d;
            strobe_q <= load_en;
        end
    end

    assign sdin          = sdin_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench: expected frames are queued when inputs are set and compared slot by slot.
module tb_i2s_dac_tx;
    import audio_defs::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] left = '0;
    logic [DW-1:0] right = '0;
    logic          mute = 1'b0;
    logic [3:0]    att = 4'd0;

    logic so0, mclk0, sclk0, lrclk0, sdin0;
    logic so1, mclk1, sclk1, lrclk1, sdin1;

    logic [8:0] tb_cnt = 9'd0;
    logic [63:0] exp0_q[$];
    logic [63:0] exp1_q[$];
    int n_checks = 0;
    int n_fail = 0;

    i2s_dac_tx #(.DW(DW), .FMT(FMT_I2S)) dut0 (
        .clk(clk), .rst(rst), .left(left), .right(right), .mute(mute), .att(att),
        .sample_strobe(so0), .mclk(mclk0), .sclk(sclk0), .lrclk(lrclk0), .sdin(sdin0)
    );

    i2s_dac_tx #(.DW(DW), .FMT(FMT_LJ)) dut1 (
        .clk(clk), .rst(rst), .left(left), .right(right), .mute(mute), .att(att),
        .sample_strobe(so1), .mclk(mclk1), .sclk(sclk1), .lrclk(lrclk1), .sdin(sdin1)
    );

    always #5 clk = ~clk;

    // Reference frame position.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 9'd0;
        else     tb_cnt <= tb_cnt + 9'd1;
    end

    // Expected sdin sequence, bit [63-k] = value in SCLK slot k.
    function automatic logic [63:0] model_frame(input int fmt, input logic [DW-1:0] l,
                                                input logic [DW-1:0] r, input logic m,
                                                input logic [3:0] a);
        logic signed [DW-1:0] sl;
        logic signed [DW-1:0] sr;
        logic [63:0] f;
        int off;
        if (m) begin
            sl = '0;
            sr = '0;
        end else begin
            sl = $signed(l) >>> a;
            sr = $signed(r) >>> a;
        end
        off = (fmt == 0) ? 1 : 0;
        f = '0;
        for (int i = 0; i < DW; i++) begin
            f[63 - (off + i)]      = sl[DW-1-i];
            f[63 - (32 + off + i)] = sr[DW-1-i];
        end
        return f;
    endfunction

    task automatic push_exp(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic m, input logic [3:0] a);
        exp0_q.push_back(model_frame(0, l, r, m, a));
        exp1_q.push_back(model_frame(1, l, r, m, a));
    endtask

    // Waits (bounded) for the next strobe, then samples one bit per SCLK slot.
    task automatic capture(output logic [63:0] c0, output logic [63:0] c1, output bit ok);
        int w;
        w = 0;
        while (so0 !== 1'b1 && w < 1100) begin
            @(negedge clk);
            w++;
        end
        ok = (so0 === 1'b1);
        c0 = '0;
        c1 = '0;
        if (ok) begin
            for (int k = 0; k < 64; k++) begin
                c0[63-k] = sdin0;
                c1[63-k] = sdin1;
                if (k < 63) repeat (8) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        int w;
        int zero_bad;
        bit ok;
        logic [63:0] c0, c1, e0, e1;
        rst = 1'b1; left = 16'h8001; right = 16'h7FFE; mute = 1'b0; att = 4'd0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({so0, mclk0, sclk0, lrclk0, sdin0, so1, mclk1, sclk1, lrclk1, sdin1} !== 10'b00000_00010) begin
            n_fail++;
            $display("FAIL reset_values: got %b want 0000000010",
                     {so0, mclk0, sclk0, lrclk0, sdin0, so1, mclk1, sclk1, lrclk1, sdin1});
        end
        push_exp(left, right, mute, att);
        rst = 1'b0;
        w = 0;
        zero_bad = 0;
        while (w < 1100) begin
            @(negedge clk);
            w++;
            if (so0 === 1'b1) break;
            if (sdin0 !== 1'b0 || sdin1 !== 1'b0) zero_bad++;
        end
        n_checks++;
        if (w != 512) begin n_fail++; $display("FAIL first_strobe: got clk %0d want 512", w); end
        n_checks++;
        if (zero_bad != 0) begin n_fail++; $display("FAIL first_frame_zero: got %0d nonzero want 0", zero_bad); end
        capture(c0, c1, ok);
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok || c0 !== e0) begin n_fail++; $display("FAIL reset_frame_i2s: got %h want %h", c0, e0); end
        n_checks++;
        if (c0 !== 64'h40008000_3FFF0000) begin n_fail++; $display("FAIL reset_frame_const: got %h want 400080003fff0000", c0); end
        n_checks++;
        if (!ok || c1 !== e1) begin n_fail++; $display("FAIL reset_frame_lj: got %h want %h", c1, e1); end
    endtask

    task automatic test_clock_ratios;
        int mr, sr, lr, st, phase_bad, edge_bad;
        logic pm, ps, pl0, pl1, pd0, pd1;
        mr = 0; sr = 0; lr = 0; st = 0; phase_bad = 0; edge_bad = 0;
        @(negedge clk);
        pm = mclk0; ps = sclk0; pl0 = lrclk0; pl1 = lrclk1; pd0 = sdin0; pd1 = sdin1;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (mclk0 && !pm) mr++;
            if (sclk0 && !ps) sr++;
            if (lrclk0 && !pl0) lr++;
            if (so0 === 1'b1) st++;
            if (mclk0 !== tb_cnt[0] || sclk0 !== tb_cnt[2] || lrclk0 !== tb_cnt[8] ||
                lrclk1 !== ~tb_cnt[8] || mclk1 !== tb_cnt[0] || sclk1 !== tb_cnt[2])
                phase_bad++;
            if ((lrclk0 !== pl0 || lrclk1 !== pl1 || sdin0 !== pd0 || sdin1 !== pd1) &&
                tb_cnt[2:0] != 3'd0)
                edge_bad++;
            pm = mclk0; ps = sclk0; pl0 = lrclk0; pl1 = lrclk1; pd0 = sdin0; pd1 = sdin1;
        end
        n_checks++;
        if (mr != 2048) begin n_fail++; $display("FAIL mclk_ratio: got %0d rises want 2048", mr); end
        n_checks++;
        if (sr != 512) begin n_fail++; $display("FAIL sclk_ratio: got %0d rises want 512", sr); end
        n_checks++;
        if (lr != 8) begin n_fail++; $display("FAIL lrclk_ratio: got %0d rises want 8", lr); end
        n_checks++;
        if (st != 8) begin n_fail++; $display("FAIL strobe_rate: got %0d want 8", st); end
        n_checks++;
        if (phase_bad != 0) begin n_fail++; $display("FAIL clock_phase: got %0d bad want 0", phase_bad); end
        n_checks++;
        if (edge_bad != 0) begin n_fail++; $display("FAIL edge_align: got %0d bad want 0", edge_bad); end
    endtask

    task automatic test_atten_mute;
        bit ok, ok2;
        logic [63:0] c0, c1, d0, d1, e0, e1;
        left = 16'h8000; right = 16'h1234; att = 4'd4; mute = 1'b0;
        push_exp(left, right, 1'b0, att);
        push_exp(left, right, 1'b1, att);
        fork
            capture(c0, c1, ok);
            begin
                for (int w = 0; w < 1100 && so0 !== 1'b1; w++) @(negedge clk);
                repeat (300) @(negedge clk);
                mute = 1'b1;
            end
        join
        capture(d0, d1, ok2);
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok || c0 !== e0 || c1 !== e1) begin n_fail++; $display("FAIL atten_frame: got %h/%h want %h/%h", c0, c1, e0, e1); end
        n_checks++;
        if (c0[62:47] !== 16'hF800) begin n_fail++; $display("FAIL atten_word: got %h want f800", c0[62:47]); end
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok2 || d0 !== e0 || d1 !== e1 || d0 !== 64'h0) begin n_fail++; $display("FAIL mute_frame: got %h/%h want %h/%h", d0, d1, e0, e1); end
        mute = 1'b0;
    endtask

    task automatic test_att_boundary;
        bit ok;
        logic [63:0] c0, c1, e0, e1;
        left = 16'h8000; right = 16'h7FFF; att = 4'd15; mute = 1'b0;
        push_exp(left, right, mute, att);
        capture(c0, c1, ok);
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok || c0 !== e0 || c1 !== e1) begin n_fail++; $display("FAIL att15_frame: got %h/%h want %h/%h", c0, c1, e0, e1); end
        n_checks++;
        if (c0[62:47] !== 16'hFFFF || c0[30:15] !== 16'h0000) begin
            n_fail++; $display("FAIL att15_words: got %h %h want ffff 0000", c0[62:47], c0[30:15]);
        end
        att = 4'd0;
    endtask

    task automatic test_mid_frame_change;
        bit ok, ok2;
        logic [63:0] c0, c1, d0, d1, e0, e1;
        left = 16'h1111; right = 16'h2222;
        push_exp(16'h1111, 16'h2222, 1'b0, 4'd0);
        push_exp(16'h3C3C, 16'h2222, 1'b0, 4'd0);
        fork
            capture(c0, c1, ok);
            begin
                for (int w = 0; w < 1100 && so0 !== 1'b1; w++) @(negedge clk);
                repeat (100) @(negedge clk);
                left = 16'h3C3C;
            end
        join
        capture(d0, d1, ok2);
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok || c0 !== e0 || c1 !== e1) begin n_fail++; $display("FAIL midchange_cur: got %h/%h want %h/%h", c0, c1, e0, e1); end
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok2 || d0 !== e0 || d1 !== e1) begin n_fail++; $display("FAIL midchange_next: got %h/%h want %h/%h", d0, d1, e0, e1); end
    endtask

    task automatic test_left_justified;
        bit ok;
        int lr_bad;
        logic [63:0] c0, c1, e0, e1;
        left = 16'hA5A5; right = 16'h5A5A;
        push_exp(left, right, 1'b0, 4'd0);
        capture(c0, c1, ok);
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok || c1 !== e1 || c0 !== e0) begin n_fail++; $display("FAIL lj_frame: got %h/%h want %h/%h", c1, c0, e1, e0); end
        n_checks++;
        if (c1 !== 64'hA5A50000_5A5A0000) begin n_fail++; $display("FAIL lj_const: got %h want a5a500005a5a0000", c1); end
        lr_bad = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (lrclk1 !== (tb_cnt < 9'd256)) lr_bad++;
        end
        n_checks++;
        if (lr_bad != 0) begin n_fail++; $display("FAIL lj_lrclk: got %0d bad want 0", lr_bad); end
    endtask

    task automatic test_reset_midframe;
        int w, zero_bad;
        bit ok;
        logic [63:0] c0, c1, e0, e1;
        left = 16'h7FFF; right = 16'h8001;
        for (w = 0; w < 600 && tb_cnt != 9'd200; w++) @(negedge clk);
        n_checks++;
        if (tb_cnt != 9'd200) begin n_fail++; $display("FAIL reach_cnt200: got %0d want 200", tb_cnt); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({so0, mclk0, sclk0, lrclk0, sdin0, so1, mclk1, sclk1, lrclk1, sdin1} !== 10'b00000_00010) begin
            n_fail++;
            $display("FAIL midreset_values: got %b want 0000000010",
                     {so0, mclk0, sclk0, lrclk0, sdin0, so1, mclk1, sclk1, lrclk1, sdin1});
        end
        push_exp(left, right, 1'b0, 4'd0);
        rst = 1'b0;
        w = 0;
        zero_bad = 0;
        while (w < 1100) begin
            @(negedge clk);
            w++;
            if (so0 === 1'b1) break;
            if (sdin0 !== 1'b0 || sdin1 !== 1'b0) zero_bad++;
        end
        n_checks++;
        if (w != 512) begin n_fail++; $display("FAIL midreset_strobe: got clk %0d want 512", w); end
        n_checks++;
        if (zero_bad != 0) begin n_fail++; $display("FAIL midreset_no_partial: got %0d nonzero want 0", zero_bad); end
        capture(c0, c1, ok);
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        n_checks++;
        if (!ok || c0 !== e0 || c1 !== e1) begin n_fail++; $display("FAIL midreset_frame: got %h/%h want %h/%h", c0, c1, e0, e1); end
    endtask

    initial begin
        test_reset();
        test_clock_ratios();
        test_atten_mute();
        test_att_boundary();
        test_mid_frame_change();
        test_left_justified();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
